// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU function
// codes, saturation limits and the imm8 sign-extension helper.
package ex_mem_stage_pkg;

  localparam int DW = 16;
  localparam int AW = 4;

  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_LHB = 3'b001;
  localparam logic [2:0] FUNC_SUB = 3'b010;
  localparam logic [2:0] FUNC_AND = 3'b011;
  localparam logic [2:0] FUNC_NOR = 3'b100;
  localparam logic [2:0] FUNC_SLL = 3'b101;
  localparam logic [2:0] FUNC_SRL = 3'b110;
  localparam logic [2:0] FUNC_SRA = 3'b111;

  localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DW-1:0] SAT_NEG = 16'h8000;

  function automatic logic [DW-1:0] sext8(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM bus.
//   *_EX  : operands and controls from the ID/EX register (driven by master)
//   *_MEM : registered result and forwarded controls (driven by slave)
//   zr/ov/ng : architectural flag register (driven by slave)
interface ex_mem_stage_if;
  import ex_mem_stage_pkg::*;

  logic [DW-1:0] p0_EX;
  logic [DW-1:0] p1_EX;
  logic [7:0]    imm8_EX;
  logic [3:0]    shamt_EX;
  logic [2:0]    func_EX;
  logic          src1sel_EX;
  logic          we_mem_EX;
  logic          re_mem_EX;
  logic          wb_sel_EX;
  logic          we_rf_EX;
  logic [AW-1:0] dst_EX;

  logic [DW-1:0] alu_MEM;
  logic [DW-1:0] sdata_MEM;
  logic          we_mem_MEM;
  logic          re_mem_MEM;
  logic          wb_sel_MEM;
  logic          we_rf_MEM;
  logic [AW-1:0] dst_MEM;
  logic          zr;
  logic          ov;
  logic          ng;

  modport master (
    output p0_EX, p1_EX, imm8_EX, shamt_EX, func_EX, src1sel_EX,
           we_mem_EX, re_mem_EX, wb_sel_EX, we_rf_EX, dst_EX,
    input  alu_MEM, sdata_MEM, we_mem_MEM, re_mem_MEM, wb_sel_MEM,
           we_rf_MEM, dst_MEM, zr, ov, ng
  );

  modport slave (
    input  p0_EX, p1_EX, imm8_EX, shamt_EX, func_EX, src1sel_EX,
           we_mem_EX, re_mem_EX, wb_sel_EX, we_rf_EX, dst_EX,
    output alu_MEM, sdata_MEM, we_mem_MEM, re_mem_MEM, wb_sel_MEM,
           we_rf_MEM, dst_MEM, zr, ov, ng
  );

endinterface

// File: rtl/ex_mem_stage_alu16.sv
// alu16: combinational 16-bit ALU.
//   src0, src1 : operands      shamt : shift amount
//   func       : function code imm8  : LHB upper byte
//   result     : ADD/SUB saturate on signed overflow
//   zr, ov, ng : raw flags of this result (the caller decides whether to keep them)
module alu16
  import ex_mem_stage_pkg::*;
(
  input  logic [DW-1:0] src0,
  input  logic [DW-1:0] src1,
  input  logic [3:0]    shamt,
  input  logic [2:0]    func,
  input  logic [7:0]    imm8,
  output logic [DW-1:0] result,
  output logic          zr,
  output logic          ov,
  output logic          ng
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic          sum_ov;
  logic          diff_ov;

  assign sum  = src0 + src1;
  assign diff = src0 - src1;

  // Signed overflow: result sign disagrees with what the operand signs imply.
  assign sum_ov  = (src0[15] == src1[15]) && (sum[15]  != src0[15]);
  assign diff_ov = (src0[15] != src1[15]) && (diff[15] != src0[15]);

  always_comb begin
    result = '0;
    ov     = 1'b0;
    case (func)
      FUNC_ADD: begin
        ov     = sum_ov;
        result = sum_ov ? (src0[15] ? SAT_NEG : SAT_POS) : sum;
      end
      FUNC_LHB: result = {imm8, src0[7:0]};
      FUNC_SUB: begin
        ov     = diff_ov;
        result = diff_ov ? (src0[15] ? SAT_NEG : SAT_POS) : diff;
      end
      FUNC_AND: result = src0 & src1;
      FUNC_NOR: result = ~(src0 | src1);
      FUNC_SLL: result = src0 << shamt;
      FUNC_SRL: result = src0 >> shamt;
      FUNC_SRA: result = $unsigned($signed(src0) >>> shamt);
      default:  result = '0;
    endcase
  end

  assign zr = (result == '0);
  assign ng = result[15];

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus EX/MEM pipeline register and Z/V/N flags.
//   clk, rst_n : clock, synchronous active-low reset
//   stall      : hold all state
//   flush      : clear the memory/regfile write and read strobes, hold the rest
//   bus        : ID/EX inputs, EX/MEM outputs and flags (slave side)
// Priority: rst_n > flush > stall > normal.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  ex_mem_stage_if.slave bus
);

  logic [DW-1:0] src1;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] ex_res;
  logic          alu_zr;
  logic          alu_ov;
  logic          alu_ng;
  logic          upd_arith;
  logic          upd_zr;

  assign src1 = bus.src1sel_EX ? sext8(bus.imm8_EX) : bus.p1_EX;

  alu16 u_alu16 (
    .src0   (bus.p0_EX),
    .src1   (src1),
    .shamt  (bus.shamt_EX),
    .func   (bus.func_EX),
    .imm8   (bus.imm8_EX),
    .result (alu_res),
    .zr     (alu_zr),
    .ov     (alu_ov),
    .ng     (alu_ng)
  );

  // Address generation wraps and bypasses the ALU function entirely.
  assign ex_res = bus.src1sel_EX ? (bus.p0_EX + src1) : alu_res;

  assign upd_arith = !bus.src1sel_EX &&
                     ((bus.func_EX == FUNC_ADD) || (bus.func_EX == FUNC_SUB));
  assign upd_zr    = !bus.src1sel_EX && (bus.func_EX != FUNC_LHB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.alu_MEM    <= '0;
      bus.sdata_MEM  <= '0;
      bus.we_mem_MEM <= 1'b0;
      bus.re_mem_MEM <= 1'b0;
      bus.wb_sel_MEM <= 1'b0;
      bus.we_rf_MEM  <= 1'b0;
      bus.dst_MEM    <= '0;
      bus.zr         <= 1'b0;
      bus.ov         <= 1'b0;
      bus.ng         <= 1'b0;
    end else if (flush) begin
      bus.we_mem_MEM <= 1'b0;
      bus.re_mem_MEM <= 1'b0;
      bus.we_rf_MEM  <= 1'b0;
    end else if (!stall) begin
      bus.alu_MEM    <= ex_res;
      bus.sdata_MEM  <= bus.p0_EX;
      bus.we_mem_MEM <= bus.we_mem_EX;
      bus.re_mem_MEM <= bus.re_mem_EX;
      bus.wb_sel_MEM <= bus.wb_sel_EX;
      bus.we_rf_MEM  <= bus.we_rf_EX;
      bus.dst_MEM    <= bus.dst_EX;
      if (upd_zr)
        bus.zr <= alu_zr;
      if (upd_arith) begin
        bus.ov <= alu_ov;
        bus.ng <= alu_ng;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected flags packed as {zr, ov, ng}.
  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {13'd0, bus.zr, bus.ov, bus.ng}, {13'd0, exp});
  endtask

  // Expected controls packed as {we_mem, re_mem, wb_sel, we_rf}.
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {12'd0, bus.we_mem_MEM, bus.re_mem_MEM, bus.wb_sel_MEM, bus.we_rf_MEM},
          {12'd0, exp});
  endtask

  task automatic set_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sh, input logic [7:0] imm, input logic s1);
    bus.func_EX    = f;
    bus.p0_EX      = a;
    bus.p1_EX      = b;
    bus.shamt_EX   = sh;
    bus.imm8_EX    = imm;
    bus.src1sel_EX = s1;
  endtask

  task automatic set_ctl(input logic [3:0] c, input logic [3:0] d);
    {bus.we_mem_EX, bus.re_mem_EX, bus.wb_sel_EX, bus.we_rf_EX} = c;
    bus.dst_EX = d;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_op(FUNC_ADD, 16'h1111, 16'h2222, 4'd0, 8'h00, 1'b0);
    set_ctl(4'b1111, 4'hF);
    tick();
    tick();
    check("rst_alu", bus.alu_MEM, 16'h0000);
    check("rst_sdata", bus.sdata_MEM, 16'h0000);
    check("rst_dst", {12'd0, bus.dst_MEM}, 16'h0000);
    check_ctl("rst_ctl", 4'b0000);
    check_flags("rst_flags", 3'b000);

    rst_n = 1'b1;
    set_op(FUNC_ADD, 16'h7FF0, 16'h0020, 4'd0, 8'h00, 1'b0);
    set_ctl(4'b0011, 4'h3);
    tick();
    check("add_pos_sat", bus.alu_MEM, 16'h7FFF);
    check_flags("add_pos_sat_flags", 3'b010);
    check("add_sdata", bus.sdata_MEM, 16'h7FF0);
    check_ctl("add_ctl", 4'b0011);
    check("add_dst", {12'd0, bus.dst_MEM}, 16'h0003);

    set_op(FUNC_SUB, 16'h8000, 16'h0001, 4'd0, 8'h00, 1'b0);
    tick();
    check("sub_neg_sat", bus.alu_MEM, 16'h8000);
    check_flags("sub_neg_sat_flags", 3'b011);

    set_op(FUNC_ADD, 16'h0010, 16'h7FFF, 4'd0, 8'hFE, 1'b1);
    set_ctl(4'b0100, 4'h1);
    tick();
    check("addr_add", bus.alu_MEM, 16'h000E);
    check_flags("addr_add_flags", 3'b011);
    check_ctl("addr_ctl", 4'b0100);

    set_op(FUNC_SRA, 16'h8001, 16'h0000, 4'd15, 8'h00, 1'b0);
    set_ctl(4'b0001, 4'h2);
    tick();
    check("sra15", bus.alu_MEM, 16'hFFFF);
    check_flags("sra15_flags", 3'b011);

    set_op(FUNC_AND, 16'h00F0, 16'h0F00, 4'd0, 8'h00, 1'b0);
    tick();
    check("and_zero", bus.alu_MEM, 16'h0000);
    check_flags("and_zero_flags", 3'b111);

    set_op(FUNC_LHB, 16'h1234, 16'h5555, 4'd0, 8'hAB, 1'b0);
    tick();
    check("lhb", bus.alu_MEM, 16'hAB34);
    check_flags("lhb_flags", 3'b111);

    set_op(FUNC_ADD, 16'h0001, 16'h0002, 4'd0, 8'h00, 1'b0);
    tick();
    check("add_plain", bus.alu_MEM, 16'h0003);
    check_flags("add_plain_flags", 3'b000);

    set_op(FUNC_NOR, 16'hFFFF, 16'h0000, 4'd0, 8'h00, 1'b0);
    tick();
    check("nor", bus.alu_MEM, 16'h0000);
    check_flags("nor_flags", 3'b100);

    set_op(FUNC_SLL, 16'h0003, 16'h0000, 4'd4, 8'h00, 1'b0);
    tick();
    check("sll4", bus.alu_MEM, 16'h0030);
    check_flags("sll4_flags", 3'b000);

    set_op(FUNC_SRL, 16'h8000, 16'h0000, 4'd15, 8'h00, 1'b0);
    tick();
    check("srl15", bus.alu_MEM, 16'h0001);

    set_op(FUNC_SLL, 16'hBEEF, 16'h0000, 4'd0, 8'h00, 1'b0);
    tick();
    check("sll0", bus.alu_MEM, 16'hBEEF);

    set_op(FUNC_ADD, 16'h8000, 16'hFFFF, 4'd0, 8'h00, 1'b0);
    tick();
    check("add_neg_sat", bus.alu_MEM, 16'h8000);
    check_flags("add_neg_sat_flags", 3'b011);

    set_op(FUNC_SUB, 16'h0005, 16'h0005, 4'd0, 8'h00, 1'b0);
    tick();
    check("sub_zero", bus.alu_MEM, 16'h0000);
    check_flags("sub_zero_flags", 3'b100);

    // Stall three cycles with changing inputs: everything frozen.
    stall = 1'b1;
    set_op(FUNC_ADD, 16'h0001, 16'h0001, 4'd0, 8'h00, 1'b0);
    set_ctl(4'b1010, 4'h9);
    tick();
    check("stall1_alu", bus.alu_MEM, 16'h0000);
    check_flags("stall1_flags", 3'b100);
    set_op(FUNC_SUB, 16'h8000, 16'h0001, 4'd0, 8'h00, 1'b0);
    tick();
    check("stall2_alu", bus.alu_MEM, 16'h0000);
    check_flags("stall2_flags", 3'b100);
    set_op(FUNC_NOR, 16'h0000, 16'h0000, 4'd0, 8'h00, 1'b0);
    tick();
    check("stall3_alu", bus.alu_MEM, 16'h0000);
    check_flags("stall3_flags", 3'b100);
    check_ctl("stall3_ctl", 4'b0001);
    check("stall3_dst", {12'd0, bus.dst_MEM}, 16'h0002);

    stall = 1'b0;
    set_op(FUNC_ADD, 16'h0004, 16'h0005, 4'd0, 8'h00, 1'b0);
    set_ctl(4'b1011, 4'h5);
    tick();
    check("release_alu", bus.alu_MEM, 16'h0009);
    check_flags("release_flags", 3'b000);
    check_ctl("release_ctl", 4'b1011);

    // Flush: strobes cleared, data/dst/wb_sel/flags held.
    flush = 1'b1;
    set_op(FUNC_SUB, 16'h0000, 16'h0001, 4'd0, 8'h00, 1'b0);
    set_ctl(4'b1101, 4'h7);
    tick();
    check_ctl("flush_ctl", 4'b0010);
    check("flush_alu", bus.alu_MEM, 16'h0009);
    check("flush_dst", {12'd0, bus.dst_MEM}, 16'h0005);
    check("flush_sdata", bus.sdata_MEM, 16'h0004);
    check_flags("flush_flags", 3'b000);

    flush = 1'b0;
    set_op(FUNC_ADD, 16'h0100, 16'h0100, 4'd0, 8'h00, 1'b0);
    set_ctl(4'b1101, 4'h7);
    tick();
    check("pre_fs_alu", bus.alu_MEM, 16'h0200);
    check_ctl("pre_fs_ctl", 4'b1101);

    flush = 1'b1;
    stall = 1'b1;
    set_op(FUNC_SUB, 16'h8000, 16'h0001, 4'd0, 8'h00, 1'b0);
    tick();
    check_ctl("flush_stall_ctl", 4'b0000);
    check("flush_stall_alu", bus.alu_MEM, 16'h0200);
    check_flags("flush_stall_flags", 3'b000);

    // Build nonzero state, then reset mid-stream while stalled and flushed.
    flush = 1'b0;
    stall = 1'b0;
    set_op(FUNC_SUB, 16'h8000, 16'h0001, 4'd0, 8'h00, 1'b0);
    set_ctl(4'b1111, 4'hC);
    tick();
    check_flags("pre_rst_flags", 3'b011);
    rst_n = 1'b0;
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("midrst_alu", bus.alu_MEM, 16'h0000);
    check("midrst_sdata", bus.sdata_MEM, 16'h0000);
    check("midrst_dst", {12'd0, bus.dst_MEM}, 16'h0000);
    check_ctl("midrst_ctl", 4'b0000);
    check_flags("midrst_flags", 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
